// File: rtl/lock_pkg.sv
// lock_pkg
// Shared definitions for the key unlock block: the controller state encoding
// and the fixed shift distance used by the data scrambler.
// When the macro KEY_UNLOCK_LOCKOUT_EN is defined, the LOCKOUT state is part
// of the encoding. Without the macro, the LOCKOUT state does not exist.
package lock_pkg;

    // Shift distance applied to the data word before it is mixed back into
    // the inverted word. This is what produces the scrambled output.
    localparam int unsigned SCRAMBLE_SHIFT = 7;

    // Controller states. The values are fixed so that both builds share
    // the same encoding.
    typedef enum logic [2:0] {
        LOCKED   = 3'd0,
        LOAD     = 3'd1,
        CHECK    = 3'd2,
        UNLOCKED = 3'd3
`ifdef KEY_UNLOCK_LOCKOUT_EN
        ,
        LOCKOUT  = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/lock_scrambler.sv
// lock_scrambler
// Purely combinational scrambler for the protected datapath. The output is
// the inverted word XORed with the word logically shifted right by
// SCRAMBLE_SHIFT.
// Ports:
//   data_in        - plaintext word
//   data_scrambled - scrambled word, same width
module lock_scrambler
    import lock_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_scrambled
);

    // The upper SCRAMBLE_SHIFT bits receive only the inverted data, because
    // the logical right shift fills them with zeros.
    assign data_scrambled = ~data_in ^ (data_in >> SCRAMBLE_SHIFT);

endmodule

// File: rtl/key_unlock_fsm.sv
// key_unlock_fsm
// Serial key lock that protects a datapath. A key is shifted in LSB first.
// The block checks the key for one cycle. A matching key unlocks the block.
// Each wrong key increments a counter of consecutive failures. While the
// block is unlocked, data passes through data_out unchanged. Otherwise,
// data_out carries a scrambled copy of the data.
//
// Build option: define KEY_UNLOCK_LOCKOUT_EN to enable the timed LOCKOUT
// state. Reaching MAX_TRIES failures then enters LOCKOUT for LOCKOUT_CYCLES
// clocks, and the failure count clears afterwards. Without the macro, a
// wrong key always returns to LOCKED, fail_cnt saturates at MAX_TRIES, and
// lockout is tied to 0.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   key_valid  - a key bit is offered this cycle
//   key_bit    - the offered key bit (LSB first)
//   key_ready  - the block accepts key bits (LOCKED / LOAD, not in reset)
//   relock     - single-cycle request to return to LOCKED (LOAD / UNLOCKED)
//   data_in    - plaintext data
//   data_out   - registered data, clear when unlocked, otherwise scrambled
//   unlocked   - registered, high while in UNLOCKED
//   lockout    - registered, high while in LOCKOUT
//   fail_cnt   - registered count of consecutive failed attempts
module key_unlock_fsm
    import lock_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    KEY_WIDTH      = 16,
    parameter logic [KEY_WIDTH-1:0]  KEY_VALUE      = 16'b1010110011001111,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    LOCKOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_valid,
    input  logic                           key_bit,
    output logic                           key_ready,
    input  logic                           relock,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           unlocked,
    output logic                           lockout,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

    localparam int BCW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
    localparam int FCW = $clog2(MAX_TRIES + 1);
    localparam logic [BCW-1:0] LAST_BIT   = BCW'(KEY_WIDTH - 1);
    localparam logic [FCW-1:0] FAIL_LIMIT = FCW'(MAX_TRIES);

    state_t                  state_q, state_d;
    logic [KEY_WIDTH-1:0]    key_q, key_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [FCW-1:0]          fail_cnt_q, fail_cnt_d;
    logic [FCW-1:0]          fail_next;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0]   data_scrambled;
    logic                    unlocked_q, unlocked_d;
    logic                    bit_accept;

`ifdef KEY_UNLOCK_LOCKOUT_EN
    localparam int LCW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCKOUT_CYCLES - 1);

    logic [LCW-1:0]          lock_cnt_q, lock_cnt_d;
    logic                    lockout_q, lockout_d;
`endif

    lock_scrambler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_scrambler (
        .data_in        (data_in),
        .data_scrambled (data_scrambled)
    );

    // key_ready is forced low during reset, so no bit is accepted while rst
    // is high, even though the state register is not yet known.
    assign key_ready  = !rst && ((state_q == LOCKED) || (state_q == LOAD));
    assign bit_accept = key_valid && key_ready;
    assign fail_next  = fail_cnt_q + FCW'(1);

    assign data_out = data_out_q;
    assign unlocked = unlocked_q;
    assign fail_cnt = fail_cnt_q;
`ifdef KEY_UNLOCK_LOCKOUT_EN
    assign lockout  = lockout_q;
`else
    assign lockout  = 1'b0;
`endif

    // Next-state logic. Every register holds its value by default. A relock
    // in LOAD wins over a bit offered in the same cycle. The last key bit
    // moves the block straight to CHECK, so CHECK lasts exactly one cycle.
    // The status flags are computed from the next state, which keeps them
    // as plain flops that have no input-to-output path.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        bit_cnt_d  = bit_cnt_q;
        fail_cnt_d = fail_cnt_q;
`ifdef KEY_UNLOCK_LOCKOUT_EN
        lock_cnt_d = lock_cnt_q;
`endif

        case (state_q)
            LOCKED, LOAD: begin
                if ((state_q == LOAD) && relock) begin
                    state_d   = LOCKED;
                    key_d     = '0;
                    bit_cnt_d = '0;
                end else if (bit_accept) begin
                    key_d[bit_cnt_q] = key_bit;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = CHECK;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = LOAD;
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end

            CHECK: begin
                if (key_q == KEY_VALUE) begin
                    state_d    = UNLOCKED;
                    fail_cnt_d = '0;
                end else begin
`ifdef KEY_UNLOCK_LOCKOUT_EN
                    fail_cnt_d = fail_next;
                    state_d    = (fail_next == FAIL_LIMIT) ? LOCKOUT : LOCKED;
`else
                    if (fail_cnt_q != FAIL_LIMIT) begin
                        fail_cnt_d = fail_next;
                    end
                    state_d = LOCKED;
`endif
                end
            end

            UNLOCKED: begin
                if (relock) begin
                    state_d   = LOCKED;
                    key_d     = '0;
                    bit_cnt_d = '0;
                end
            end

`ifdef KEY_UNLOCK_LOCKOUT_EN
            LOCKOUT: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = LOCKED;
                    fail_cnt_d = '0;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end
            end
`endif

            default: begin
                state_d   = LOCKED;
                key_d     = '0;
                bit_cnt_d = '0;
            end
        endcase

        unlocked_d = (state_d == UNLOCKED);
`ifdef KEY_UNLOCK_LOCKOUT_EN
        lockout_d  = (state_d == LOCKOUT);
`endif

        // The output data depends on the current state. This makes the
        // clear output appear one cycle after the block reaches UNLOCKED.
        data_out_d = (state_q == UNLOCKED) ? data_in : data_scrambled;
    end

    // State register. Reset overrides every input in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOCKED;
            key_q      <= '0;
            bit_cnt_q  <= '0;
            fail_cnt_q <= '0;
            data_out_q <= '0;
            unlocked_q <= 1'b0;
`ifdef KEY_UNLOCK_LOCKOUT_EN
            lock_cnt_q <= '0;
            lockout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            bit_cnt_q  <= bit_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            data_out_q <= data_out_d;
            unlocked_q <= unlocked_d;
`ifdef KEY_UNLOCK_LOCKOUT_EN
            lock_cnt_q <= lock_cnt_d;
            lockout_q  <= lockout_d;
`endif
        end
    end

endmodule

// File: tb/tb_key_unlock_fsm.sv
// tb_key_unlock_fsm
// Self-checking bench for key_unlock_fsm with a 16-bit key 16'hACCF,
// MAX_TRIES 3 and LOCKOUT_CYCLES 8. A behavioural model follows the lock at
// the level of "bits collected so far / check pending / unlocked / lockout
// cycles left". Every cycle is compared against this model. Directed
// tables and sequences add fixed expected values for the corner cases.
// The lockout checks follow the KEY_UNLOCK_LOCKOUT_EN macro, in the same
// way as the design.
module tb_key_unlock_fsm;

    localparam int DW = 32;
    localparam int KW = 16;
    localparam int MT = 3;
    localparam int LC = 8;
    localparam logic [KW-1:0] GOOD_KEY = 16'hACCF;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic          key_bit;
    logic          key_ready;
    logic          relock;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          unlocked;
    logic          lockout;
    logic [1:0]    fail_cnt;

    int checkCount = 0;
    int passCount  = 0;

    // Behavioural reference state
    bit            mUnlocked     = 1'b0;
    bit            mCheckPending = 1'b0;
    int            mLockoutLeft  = 0;
    int            mFails        = 0;
    bit            mBits[$];
    logic [DW-1:0] mDataOut      = '0;

    typedef struct {
        bit            rstIn;
        logic [DW-1:0] dataIn;
        logic [DW-1:0] expData;
        bit            expUnlocked;
    } vec_t;

    vec_t vecs[7];

    key_unlock_fsm #(
        .DATA_WIDTH     (DW),
        .KEY_WIDTH      (KW),
        .KEY_VALUE      (GOOD_KEY),
        .MAX_TRIES      (MT),
        .LOCKOUT_CYCLES (LC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_bit   (key_bit),
        .key_ready (key_ready),
        .relock    (relock),
        .data_in   (data_in),
        .data_out  (data_out),
        .unlocked  (unlocked),
        .lockout   (lockout),
        .fail_cnt  (fail_cnt)
    );

    // Free-running clock with a 10-unit period
    always #5 clk = ~clk;

    // Count one comparison and report it if it fails
    task automatic expectEq(input string name, input logic [63:0] actual,
                            input logic [63:0] required);
        checkCount++;
        if (actual === required) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, required, $time);
        end
    endtask

    // The lock accepts bits unless it is unlocked, locked out, or busy with
    // the one-cycle check
    function automatic bit modelReady();
        return !mUnlocked && (mLockoutLeft == 0) && !mCheckPending;
    endfunction

    // Advance the model by one clock edge, following the rules of the lock
    function automatic void modelStep(input bit r, input bit v, input bit b,
                                      input bit rl, input logic [DW-1:0] d);
        logic [KW-1:0] word;
        word = '0;
        if (r) begin
            mUnlocked     = 1'b0;
            mCheckPending = 1'b0;
            mLockoutLeft  = 0;
            mFails        = 0;
            mBits.delete();
            mDataOut      = '0;
            return;
        end
        mDataOut = mUnlocked ? d : (~d ^ (d >> 7));
        if (mCheckPending) begin
            for (int i = 0; i < KW; i++) word[i] = mBits[i];
            mBits.delete();
            mCheckPending = 1'b0;
            if (word == GOOD_KEY) begin
                mUnlocked = 1'b1;
                mFails    = 0;
            end else begin
                mFails++;
`ifdef KEY_UNLOCK_LOCKOUT_EN
                if (mFails == MT) mLockoutLeft = LC;
`else
                if (mFails > MT) mFails = MT;
`endif
            end
        end else if (mLockoutLeft > 0) begin
            mLockoutLeft--;
            if (mLockoutLeft == 0) mFails = 0;
        end else if (mUnlocked) begin
            if (rl) mUnlocked = 1'b0;
        end else if (rl && (mBits.size() > 0)) begin
            mBits.delete();
        end else if (v) begin
            mBits.push_back(b);
            if (mBits.size() == KW) mCheckPending = 1'b1;
        end
    endfunction

    // Compare the registered outputs against the model
    task automatic checkOutput();
        expectEq("unlocked", unlocked, mUnlocked);
        expectEq("lockout", lockout, (mLockoutLeft > 0));
        expectEq("fail_cnt", fail_cnt, mFails);
        expectEq("data_out", data_out, mDataOut);
    endtask

    // Drive one cycle of inputs, check key_ready before the edge, then
    // check the registered outputs shortly after the edge
    task automatic applyStimulus(input bit r, input bit v, input bit b,
                                 input bit rl, input logic [DW-1:0] d);
        rst       = r;
        key_valid = v;
        key_bit   = b;
        relock    = rl;
        data_in   = d;
        #1;
        expectEq("key_ready", key_ready, (!r && modelReady()));
        @(posedge clk);
        modelStep(r, v, b, rl, d);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    endtask

    task automatic sendKey(input logic [KW-1:0] k);
        for (int i = 0; i < KW; i++) applyStimulus(1'b0, 1'b1, k[i], 1'b0, $urandom);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[3] = '{1'b0, 32'h1234_5678, 32'hEDEF_C12B, 1'b0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h01FF_FFFF, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'h7EFF_FFFF, 1'b0};

        // Reset values and the scrambled output while locked
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].rstIn, 1'b0, 1'b0, 1'b0, vecs[i].dataIn);
            expectEq("vec_data_out", data_out, vecs[i].expData);
            expectEq("vec_unlocked", unlocked, vecs[i].expUnlocked);
        end

        // Correct key: the block is in CHECK one cycle after the last bit,
        // UNLOCKED the cycle after that, and then passes data through
        doReset();
        sendKey(GOOD_KEY);
        expectEq("check_unlocked", unlocked, 1'b0);
        expectEq("check_key_ready", key_ready, 1'b0);
        idle(1);
        expectEq("unlock_latency", unlocked, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
        expectEq("clear_data", data_out, 32'h1234_5678);

        // Reset while unlocked
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000);
        expectEq("rst_unlocked", unlocked, 1'b0);
        expectEq("rst_data_out", data_out, 32'h0);

        // Relock pulse while unlocked, then the scrambled output resumes
        sendKey(GOOD_KEY);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
        expectEq("relock_unlocked", unlocked, 1'b0);
        expectEq("relock_last_clear", data_out, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0001);
        expectEq("relock_scrambled", data_out, 32'hFFFF_FFFE);

        // Relock after five bits, together with a valid bit: the bit is
        // dropped, and a fresh full key still unlocks
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, GOOD_KEY[i], 1'b0, $urandom);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, $urandom);
        expectEq("relock_load_ready", key_ready, 1'b1);
        sendKey(GOOD_KEY);
        idle(1);
        expectEq("relock_then_unlock", unlocked, 1'b1);

        // Repeated wrong keys
        doReset();
`ifdef KEY_UNLOCK_LOCKOUT_EN
        for (int t = 1; t <= 3; t++) begin
            sendKey(16'h0000);
            idle(1);
            expectEq("wrong_fail_cnt", fail_cnt, t);
        end
        expectEq("lockout_enter", lockout, 1'b1);
        expectEq("lockout_key_ready", key_ready, 1'b0);
        for (int j = 0; j < LC - 1; j++) begin
            idle(1);
            expectEq("lockout_hold", lockout, 1'b1);
            expectEq("lockout_key_ready", key_ready, 1'b0);
        end
        idle(1);
        expectEq("lockout_exit", lockout, 1'b0);
        expectEq("lockout_fail_clear", fail_cnt, 2'd0);
        expectEq("lockout_exit_ready", key_ready, 1'b1);
`else
        for (int t = 1; t <= 4; t++) begin
            sendKey(16'h0000);
            idle(1);
            expectEq("wrong_fail_cnt", fail_cnt, (t > MT) ? MT : t);
            expectEq("wrong_lockout", lockout, 1'b0);
            expectEq("wrong_key_ready", key_ready, 1'b1);
        end
`endif

        // Randomized traffic against the model, with frequent correct keys
        doReset();
        for (int round = 0; round < 25; round++) begin
            if (($urandom % 2) == 1) sendKey(GOOD_KEY);
            else sendKey(KW'($urandom));
            for (int c = 0; c < 20; c++) begin
                applyStimulus(($urandom % 53) == 0, ($urandom % 4) != 0,
                              ($urandom % 2) == 1, ($urandom % 12) == 0,
                              $urandom);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/key_unlock_fsm.md
KEY_UNLOCK_FSM -- requirements
Module: key_unlock_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, protected datapath width.
REQ-002 SHALL have parameter KEY_WIDTH, default 16, key length in bits (1..64).
REQ-003 SHALL have parameter KEY_VALUE, default 16'b1010110011001111, correct key.
REQ-004 SHALL have parameter MAX_TRIES, default 3, failed attempts before lockout (>=1).
REQ-005 SHALL have parameter LOCKOUT_CYCLES, default 256, lockout duration in clocks (>=1).
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-008 SHALL have port key_valid  input  1  serial key bit offered.
REQ-009 SHALL have port key_bit  input  1  key bit, LSB first.
REQ-010 SHALL have port key_ready  output  1  block accepts key bits.
REQ-011 SHALL have port relock  input  1  single-cycle request to return to locked.
REQ-012 SHALL have port data_in  input  DATA_WIDTH  plaintext data.
REQ-013 SHALL have port data_out  output  DATA_WIDTH  registered data, clear or scrambled.
REQ-014 SHALL have port unlocked  output  1  high iff state is UNLOCKED.
REQ-015 SHALL have port lockout  output  1  high iff state is LOCKOUT.
REQ-016 SHALL have port fail_cnt  output  $clog2(MAX_TRIES+1)  consecutive failed attempts.

Function
REQ-017 SHALL implement states LOCKED, LOAD, CHECK, UNLOCKED, LOCKOUT.
REQ-018 SHALL drive key_ready high only in LOCKED and LOAD; a bit is accepted when key_valid && key_ready.
REQ-019 SHALL, on an accepted bit, shift it into the key register at index bit_cnt and increment bit_cnt; LOCKED -> LOAD on the first bit.
REQ-020 SHALL go LOAD -> CHECK in the cycle after bit KEY_WIDTH-1 is accepted, clearing bit_cnt.
REQ-021 SHALL, in CHECK (exactly one cycle, key_ready low), compare the key register to KEY_VALUE: match -> UNLOCKED, fail_cnt <= 0; mismatch -> fail_cnt+1, then LOCKOUT if the new count equals MAX_TRIES, else LOCKED.
REQ-022 SHALL hold LOCKOUT for exactly LOCKOUT_CYCLES cycles, then enter LOCKED with fail_cnt <= 0.
REQ-023 SHALL, when relock is high in LOAD or UNLOCKED, go to LOCKED next cycle and clear the key register and bit_cnt; relock SHALL be ignored in LOCKED, CHECK and LOCKOUT.
REQ-024 SHALL give relock priority over a simultaneously accepted key bit in LOAD (bit discarded).
REQ-025 SHALL register data_out with 1-cycle latency: data_out(n+1) = data_in(n) if state(n)==UNLOCKED, else ~data_in(n) ^ (data_in(n) >> 7).
REQ-026 SHALL drive unlocked, lockout and fail_cnt directly from registers, no combinational path from inputs.

Reset
REQ-027 SHALL, while rst is high at a clock edge, set state LOCKED, data_out 0, key register 0, bit_cnt 0, fail_cnt 0, lockout counter 0; key_ready SHALL be 0 while rst is high.
REQ-028 SHALL treat rst as overriding every other input in every state, including mid-LOAD and mid-LOCKOUT.

Configuration
REQ-029 SHALL, with macro KEY_UNLOCK_LOCKOUT_EN defined, implement LOCKOUT as specified.
REQ-030 SHALL, without KEY_UNLOCK_LOCKOUT_EN, omit LOCKOUT state and counter: a mismatch always returns to LOCKED, fail_cnt saturates at MAX_TRIES, lockout tied 0.

Structure
REQ-031 SHALL place the state enum typedef and the scramble shift constant (7) in shared package lock_pkg.
REQ-032 SHALL isolate the scramble function in combinational sub-module lock_scrambler (DATA_WIDTH parameter).

Verification (KEY_WIDTH=16, KEY_VALUE=16'hACCF, MAX_TRIES=3, LOCKOUT_CYCLES=8)
REQ-033 SHALL check: after reset, data_in=32'h0000_0001 held -> data_out=32'hFFFF_FFFE one cycle later, unlocked=0.
REQ-034 SHALL check: 16'hACCF shifted LSB first, last bit at cycle n -> unlocked=1 at n+2; data_in=32'h1234_5678 -> data_out=32'h1234_5678 next cycle.
REQ-035 SHALL check: three keys 16'h0000 -> fail_cnt 1, 2, then lockout=1 and key_ready=0 for 8 cycles, then LOCKED with fail_cnt=0.
REQ-036 SHALL check: relock after 5 bits in LOAD, concurrent with key_valid -> LOCKED, bit discarded; a following full 16'hACCF unlocks.
REQ-037 SHALL check: rst asserted in UNLOCKED -> unlocked=0, data_out=0 next cycle; relock pulse in UNLOCKED -> LOCKED and scrambled output resumes.
REQ-038 SHALL check: without KEY_UNLOCK_LOCKOUT_EN, four wrong keys -> lockout stays 0, fail_cnt saturates at 3, key_ready returns high after each CHECK.
